// File: rtl/spifi_pkg.sv
// Shared AHB-Lite encodings and line-fill FSM states for the SPIFI line-fetch path.
package spifi_pkg;

    localparam int LINE_WORDS = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        ERR
    } fetch_state_e;

    // Beat addresses wrap inside the 16-byte line; the base never advances.
    function automatic logic [31:0] beat_addr(input logic [27:0] base, input logic [1:0] idx);
        return {base, idx, 2'b00};
    endfunction

endpackage

// File: rtl/spifi_line_fetch_if.sv
// Cache request/response and AHB-Lite memory-port signals of the line-fetch engine.
interface spifi_line_fetch_if;

    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;

    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_idx;
    logic        o_rsp_last;
    logic        o_rsp_err;

    logic        o_hsel_sl;
    logic        o_hready_i_sl;
    logic [31:0] o_haddr_sl;
    logic        o_hwrite_sl;
    logic [2:0]  o_hsize_sl;
    logic [2:0]  o_hburst_sl;
    logic [3:0]  o_hprot_sl;
    logic [1:0]  o_htrans_sl;
    logic        o_hmastlock_sl;
    logic [31:0] o_hwdata_sl;
    logic [31:0] i_hrdata_sl;
    logic        i_hready_o_sl;
    logic        i_hresp_sl;

    // The engine is the AHB master; the cache and SPIFI controller form the other side.
    modport master (
        input  i_req_valid, i_req_addr, i_hrdata_sl, i_hready_o_sl, i_hresp_sl,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_idx, o_rsp_last, o_rsp_err,
        output o_hsel_sl, o_hready_i_sl, o_haddr_sl, o_hwrite_sl, o_hsize_sl, o_hburst_sl,
        output o_hprot_sl, o_htrans_sl, o_hmastlock_sl, o_hwdata_sl
    );

    modport slave (
        output i_req_valid, i_req_addr, i_hrdata_sl, i_hready_o_sl, i_hresp_sl,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_idx, o_rsp_last, o_rsp_err,
        input  o_hsel_sl, o_hready_i_sl, o_haddr_sl, o_hwrite_sl, o_hsize_sl, o_hburst_sl,
        input  o_hprot_sl, o_htrans_sl, o_hmastlock_sl, o_hwdata_sl
    );

endinterface

// File: rtl/spifi_line_fetch.sv
// Line-fill engine: one WRAP4 critical-word-first AHB-Lite read burst per cache miss,
// returning each word with its line index and reporting AHB errors.
module spifi_line_fetch
    import spifi_pkg::*;
(
    input  logic               i_hclk,
    input  logic               i_hreset,
    spifi_line_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [27:0]  base_q, base_d;
    logic [1:0]   start_q, start_d;
    logic [2:0]   a_cnt_q, a_cnt_d;
    logic [1:0]   d_cnt_q, d_cnt_d;
    logic         dpend_q, dpend_d;
    logic [1:0]   didx_q, didx_d;
    logic         hsel_q, hsel_d;
    logic [1:0]   htrans_q, htrans_d;
    logic [31:0]  haddr_q, haddr_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_data_q, rsp_data_d;
    logic [1:0]   rsp_idx_q, rsp_idx_d;
    logic         rsp_last_q, rsp_last_d;
    logic         rsp_err_q, rsp_err_d;

    logic         unused_addr_bits;
    assign unused_addr_bits = ^bus.i_req_addr[1:0];

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            start_q     <= '0;
            a_cnt_q     <= '0;
            d_cnt_q     <= '0;
            dpend_q     <= 1'b0;
            didx_q      <= '0;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            start_q     <= start_d;
            a_cnt_q     <= a_cnt_d;
            d_cnt_q     <= d_cnt_d;
            dpend_q     <= dpend_d;
            didx_q      <= didx_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        start_d     = start_q;
        a_cnt_d     = a_cnt_q;
        d_cnt_d     = d_cnt_q;
        dpend_d     = dpend_q;
        didx_d      = didx_q;
        hsel_d      = hsel_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    base_d   = bus.i_req_addr[31:4];
                    start_d  = bus.i_req_addr[3:2];
                    haddr_d  = beat_addr(bus.i_req_addr[31:4], bus.i_req_addr[3:2]);
                    htrans_d = HTRANS_NONSEQ;
                    hsel_d   = 1'b1;
                    a_cnt_d  = 3'd1;
                    d_cnt_d  = 2'd0;
                    dpend_d  = 1'b0;
                    state_d  = BURST;
                end
            end

            BURST: begin
                if (bus.i_hready_o_sl) begin
                    // A completed address phase becomes the next data phase.
                    if (htrans_q != HTRANS_IDLE) begin
                        dpend_d = 1'b1;
                        didx_d  = haddr_q[3:2];
                        if (a_cnt_q != 3'(LINE_WORDS)) begin
                            htrans_d = HTRANS_SEQ;
                            haddr_d  = beat_addr(base_q, start_q + a_cnt_q[1:0]);
                            a_cnt_d  = a_cnt_q + 3'd1;
                        end else begin
                            htrans_d = HTRANS_IDLE;
                        end
                    end else begin
                        dpend_d = 1'b0;
                    end
                    if (dpend_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.i_hrdata_sl;
                        rsp_idx_d   = didx_q;
                        rsp_last_d  = (d_cnt_q == 2'd3);
                        d_cnt_d     = d_cnt_q + 2'd1;
                        if (d_cnt_q == 2'd3) begin
                            state_d  = IDLE;
                            hsel_d   = 1'b0;
                            htrans_d = HTRANS_IDLE;
                            dpend_d  = 1'b0;
                        end
                    end
                end else if (dpend_q && bus.i_hresp_sl) begin
                    // First error cycle: cancel the pending beat before the slave completes it.
                    htrans_d = HTRANS_IDLE;
                    state_d  = ERR;
                end
            end

            ERR: begin
                if (bus.i_hready_o_sl) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_idx_d   = didx_q;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                    hsel_d      = 1'b0;
                    htrans_d    = HTRANS_IDLE;
                    dpend_d     = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.o_req_ready    = (state_q == IDLE);
    assign bus.o_rsp_valid    = rsp_valid_q;
    assign bus.o_rsp_data     = rsp_data_q;
    assign bus.o_rsp_idx      = rsp_idx_q;
    assign bus.o_rsp_last     = rsp_last_q;
    assign bus.o_rsp_err      = rsp_err_q;

    assign bus.o_hsel_sl      = hsel_q;
    assign bus.o_hready_i_sl  = bus.i_hready_o_sl;
    assign bus.o_haddr_sl     = haddr_q;
    assign bus.o_htrans_sl    = htrans_q;
    assign bus.o_hwrite_sl    = 1'b0;
    assign bus.o_hsize_sl     = HSIZE_WORD;
    assign bus.o_hburst_sl    = HBURST_WRAP4;
    assign bus.o_hprot_sl     = HPROT_DATA;
    assign bus.o_hmastlock_sl = 1'b0;
    assign bus.o_hwdata_sl    = '0;

endmodule

// File: tb/tb_spifi_line_fetch.sv
// Directed bench for spifi_line_fetch: a small AHB slave model driven cycle by cycle
// from a table of line-fill vectors, plus reset and back-to-back sequences.
module tb_spifi_line_fetch;

    typedef struct {
        logic [31:0] addr;
        int          waits;
        int          err_beat;
        logic [7:0]  idx;
        int          nrsp;
        int          first;
        int          ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[7];

    spifi_line_fetch_if bus();

    spifi_line_fetch dut (
        .i_hclk   (clk),
        .i_hreset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one fill; cycle 0 is the accept cycle, outputs are sampled at each negedge.
    task automatic applyStimulus(input vec_t v, input bit pre_issued, input bit keep_valid,
                                 input logic [31:0] next_addr);
        int          cyc = 0;
        int          nbeat = 0;
        int          nrsp = 0;
        int          first_rsp = -1;
        int          waited = 0;
        int          dp_beat = 0;
        int          err_phase = 0;
        bit          dp_valid = 0;
        bit          addr_held = 0;
        bit          err_seen = 0;
        bit          done = 0;
        logic [31:0] dp_addr = '0;
        logic [31:0] held_addr = '0;
        logic [1:0]  held_trans = '0;
        logic [1:0]  idx;
        if (!pre_issued) begin
            @(negedge clk);
            bus.i_req_valid = 1'b1;
            bus.i_req_addr  = v.addr;
        end
        checkOutput("accept_ready", bus.o_req_ready, 1);
        bus.i_hready_o_sl = 1'b1;
        bus.i_hresp_sl    = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.i_req_valid = keep_valid;
                bus.i_req_addr  = next_addr;
                checkOutput("hsel_burst", bus.o_hsel_sl, 1);
            end
            if (bus.o_rsp_valid) begin
                if (nrsp == 0) first_rsp = cyc;
                if (nrsp < 4) begin
                    idx = v.idx[2*nrsp +: 2];
                    checkOutput("rsp_idx", bus.o_rsp_idx, idx);
                    if (nrsp == v.err_beat) begin
                        checkOutput("rsp_err", bus.o_rsp_err, 1);
                        checkOutput("rsp_err_last", bus.o_rsp_last, 1);
                        checkOutput("rsp_err_data", bus.o_rsp_data, 0);
                    end else begin
                        checkOutput("rsp_err", bus.o_rsp_err, 0);
                        checkOutput("rsp_last", bus.o_rsp_last, (nrsp == 3));
                        checkOutput("rsp_data", bus.o_rsp_data, mem_word({v.addr[31:4], idx, 2'b00}));
                    end
                end
                nrsp++;
            end
            if (bus.o_req_ready) begin
                checkOutput("ready_cycle", cyc, v.ready);
                done = 1;
            end
            if (err_seen) begin
                checkOutput("idle_after_err", bus.o_htrans_sl, 2'b00);
            end else if (bus.o_htrans_sl != 2'b00) begin
                if (addr_held) begin
                    checkOutput("haddr_hold", bus.o_haddr_sl, held_addr);
                    checkOutput("htrans_hold", bus.o_htrans_sl, held_trans);
                end else if (nbeat < 4) begin
                    checkOutput("htrans_beat", bus.o_htrans_sl, (nbeat == 0) ? 2'b10 : 2'b11);
                    checkOutput("haddr_beat", bus.o_haddr_sl, {v.addr[31:4], v.idx[2*nbeat +: 2], 2'b00});
                    nbeat++;
                end else begin
                    checkOutput("beat_count", nbeat + 1, 4);
                end
                held_addr  = bus.o_haddr_sl;
                held_trans = bus.o_htrans_sl;
            end
            bus.i_hresp_sl    = 1'b0;
            bus.i_hready_o_sl = 1'b1;
            if (dp_valid) begin
                if (dp_beat == v.err_beat) begin
                    bus.i_hresp_sl = 1'b1;
                    if (err_phase == 0) begin
                        bus.i_hready_o_sl = 1'b0;
                        err_phase = 1;
                        err_seen  = 1;
                    end
                end else if (waited < v.waits) begin
                    bus.i_hready_o_sl = 1'b0;
                    waited++;
                end
            end
            bus.i_hrdata_sl = (dp_valid && bus.i_hready_o_sl && !bus.i_hresp_sl) ?
                              mem_word(dp_addr) : 32'hBAD0_BAD0;
            if (bus.i_hready_o_sl) begin
                addr_held = 0;
                if (bus.o_htrans_sl != 2'b00) begin
                    dp_valid  = 1;
                    dp_beat   = nbeat - 1;
                    dp_addr   = bus.o_haddr_sl;
                    waited    = 0;
                    err_phase = 0;
                end else begin
                    dp_valid = 0;
                end
            end else begin
                addr_held = (bus.o_htrans_sl != 2'b00);
            end
        end
        checkOutput("done_in_budget", done, 1);
        checkOutput("rsp_count", nrsp, v.nrsp);
        checkOutput("first_rsp_cycle", first_rsp, v.first);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{addr: 32'h0000_1008, waits: 0, err_beat: 4, idx: 8'h4E, nrsp: 4, first: 3, ready: 6};
        vecs[1] = '{addr: 32'h0000_2000, waits: 2, err_beat: 4, idx: 8'hE4, nrsp: 4, first: 5, ready: 14};
        vecs[2] = '{addr: 32'h0000_3000, waits: 0, err_beat: 1, idx: 8'hE4, nrsp: 2, first: 3, ready: 5};
        vecs[3] = '{addr: 32'h0000_ABCC, waits: 1, err_beat: 4, idx: 8'h93, nrsp: 4, first: 4, ready: 10};
        vecs[4] = '{addr: 32'h0000_4004, waits: 0, err_beat: 0, idx: 8'h39, nrsp: 1, first: 4, ready: 4};
        vecs[5] = '{addr: 32'hFFFF_FFFC, waits: 1, err_beat: 3, idx: 8'h93, nrsp: 4, first: 4, ready: 10};
        vecs[6] = '{addr: 32'h0000_6004, waits: 0, err_beat: 4, idx: 8'h39, nrsp: 4, first: 3, ready: 6};

        rst               = 1'b1;
        bus.i_req_valid   = 1'b0;
        bus.i_req_addr    = '0;
        bus.i_hrdata_sl   = '0;
        bus.i_hready_o_sl = 1'b1;
        bus.i_hresp_sl    = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset_req_ready", bus.o_req_ready, 1);
        checkOutput("reset_hsel", bus.o_hsel_sl, 0);
        checkOutput("reset_htrans", bus.o_htrans_sl, 2'b00);
        checkOutput("reset_haddr", bus.o_haddr_sl, 0);
        checkOutput("reset_rsp_valid", bus.o_rsp_valid, 0);
        checkOutput("reset_rsp_data", bus.o_rsp_data, 0);
        checkOutput("reset_rsp_idx", bus.o_rsp_idx, 0);
        checkOutput("reset_rsp_last", bus.o_rsp_last, 0);
        checkOutput("reset_rsp_err", bus.o_rsp_err, 0);
        checkOutput("const_hsize", bus.o_hsize_sl, 3'b010);
        checkOutput("const_hburst", bus.o_hburst_sl, 3'b010);
        checkOutput("const_hprot", bus.o_hprot_sl, 4'b0011);
        checkOutput("const_hwrite", bus.o_hwrite_sl, 0);
        checkOutput("const_hmastlock", bus.o_hmastlock_sl, 0);
        checkOutput("const_hwdata", bus.o_hwdata_sl, 0);
        bus.i_hready_o_sl = 1'b0;
        #1 checkOutput("hready_passthru_lo", bus.o_hready_i_sl, 0);
        bus.i_hready_o_sl = 1'b1;
        #1 checkOutput("hready_passthru_hi", bus.o_hready_i_sl, 1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d addr %h", i, vecs[i].addr);
            applyStimulus(vecs[i], 1'b0, 1'b0, 32'h0);
        end

        $display("[TB] back-to-back requests");
        applyStimulus(vecs[0], 1'b0, 1'b1, vecs[6].addr);
        applyStimulus(vecs[6], 1'b1, 1'b0, 32'h0);

        $display("[TB] reset mid-burst");
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h0000_5000;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        checkOutput("pre_reset_htrans", bus.o_htrans_sl, 2'b10);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_rsp_valid", bus.o_rsp_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_htrans", bus.o_htrans_sl, 2'b00);
        checkOutput("mid_reset_hsel", bus.o_hsel_sl, 0);
        checkOutput("mid_reset_rsp_valid", bus.o_rsp_valid, 0);
        checkOutput("mid_reset_haddr", bus.o_haddr_sl, 0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_reset_ready", bus.o_req_ready, 1);
        applyStimulus(vecs[0], 1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
